wb_tft_controller: RTL and testbench

- Wishbone slave that generates RGB TFT panel timing: pixel clock, hsync, vsync, data enable, display enable.
- Drives either a solid fill colour or 8-bar colour test pattern on 24-bit RGB.
- Sits behind the Wishbone interconnect as a peripheral slave.
- Exposes control, status, colour and frame-count registers, plus an end-of-frame interrupt.

---
 rtl/wb_tft_controller.sv | 195 +++++++++++++++++++
 tb/tb_wb_tft_controller.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_tft_controller.sv
// Wishbone TFT timing generator: sync/DE timing plus solid fill or colour bars.
// Registers: CONTROL, STATUS, FILL_COLOR, GEOMETRY, FRAME_COUNT; end-of-frame irq.
module wb_tft_controller #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int PCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_int_o,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        pclk,
    output logic        disp_en,
    output logic        hsync,
    output logic        vsync,
    output logic        data_en
);

    typedef logic [15:0] cnt_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;

    localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t HS_BEG  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
    localparam cnt_t V_ALAST = cnt_t'(V_ACTIVE - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t VS_BEG  = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam cnt_t BAR_W   = cnt_t'(H_ACTIVE / 8);

    localparam logic [PW-1:0] P_LAST = PW'(PCLK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(PCLK_DIV / 2);

    logic          en;
    logic          ie;
    logic          pat;
    logic [23:0]   fill;
    logic [23:0]   fill_pix;
    logic          frame_done;
    logic [31:0]   frame_cnt;
    logic [PW-1:0] presc;
    cnt_t          hcnt;
    cnt_t          vcnt;

    logic        bus_req;
    logic [2:0]  sel;
    logic        status_rd;
    logic        tick;
    logic        eof;
    logic        in_vblank;
    logic [31:0] rd_data;
    cnt_t        bar_q;
    logic [2:0]  bar;
    logic        active;
    logic [23:0] pix_rgb;
    logic        unused_bits;

    assign bus_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign sel       = wbs_adr_i[2:0];
    assign status_rd = bus_req & ~wbs_we_i & (sel == 3'd1);
    assign tick      = en && (presc == P_LAST);
    assign eof       = tick && (hcnt == H_LAST) && (vcnt == V_ALAST);
    assign in_vblank = vcnt >= V_ACT;

    assign bar_q   = hcnt / BAR_W;
    assign bar     = bar_q[2:0];
    assign active  = (hcnt < H_ACT) && (vcnt < V_ACT);
    // Bar order white..black maps to R=~b1, G=~b2, B=~b0.
    assign pix_rgb = pat ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}}
                         : fill_pix;

    assign unused_bits = ^{wbs_adr_i[31:3], wbs_dat_i[31:24], bar_q[15:3]};

    always_comb begin
        rd_data = 32'd0;
        unique case (1'b1)
            (sel == 3'd0): rd_data = {29'd0, pat, ie, en};
            (sel == 3'd1): rd_data = {30'd0, in_vblank, frame_done};
            (sel == 3'd2): rd_data = {8'd0, fill};
            (sel == 3'd3): rd_data = {16'(H_ACTIVE), 16'(V_ACTIVE)};
            (sel == 3'd4): rd_data = frame_cnt;
            default:       rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            en        <= 1'b0;
            ie        <= 1'b0;
            pat       <= 1'b0;
            fill      <= 24'd0;
        end else begin
            wbs_ack_o <= bus_req;
            if (bus_req) begin
                if (wbs_we_i) begin
                    if (sel == 3'd0) {pat, ie, en} <= wbs_dat_i[2:0];
                    if (sel == 3'd2) fill <= wbs_dat_i[23:0];
                end else begin
                    wbs_dat_o <= rd_data;
                end
            end
        end
    end

    // A frame end in the same clk as a STATUS read keeps FRAME_DONE set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done <= 1'b0;
            frame_cnt  <= 32'd0;
            wbs_int_o  <= 1'b0;
        end else begin
            if (eof) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 32'd1;
            end else if (status_rd) begin
                frame_done <= 1'b0;
            end
            wbs_int_o <= ie & frame_done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            hcnt     <= '0;
            vcnt     <= '0;
            fill_pix <= 24'd0;
        end else begin
            if (!en || tick) fill_pix <= fill;
            if (!en) begin
                presc <= '0;
                hcnt  <= '0;
                vcnt  <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    if (hcnt == H_LAST) begin
                        hcnt <= '0;
                        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 16'd1;
                    end else begin
                        hcnt <= hcnt + 16'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {red, green, blue} <= 24'd0;
            pclk    <= 1'b0;
            disp_en <= 1'b0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            data_en <= 1'b0;
        end else if (!en) begin
            {red, green, blue} <= 24'd0;
            pclk    <= 1'b0;
            disp_en <= 1'b0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            data_en <= 1'b0;
        end else begin
            {red, green, blue} <= active ? pix_rgb : 24'd0;
            pclk    <= presc < P_HALF;
            disp_en <= 1'b1;
            hsync   <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
            vsync   <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
            data_en <= active;
        end
    end

endmodule

// File: tb/tb_wb_tft_controller.sv
// Directed bench for wb_tft_controller using a small 12x7 timing grid.
// A second default-geometry instance covers the GEOMETRY register.
module tb_wb_tft_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        ack;
    logic        intr;
    logic [7:0]  red, green, blue;
    logic        pclk, disp_en, hsync, vsync, data_en;

    logic        d_cyc = 1'b0;
    logic        d_stb = 1'b0;
    logic [31:0] d_adr = 32'd0;
    logic [31:0] d_dat_o;
    logic        d_ack, d_int, d_pclk, d_disp, d_hs, d_vs, d_de;
    logic [7:0]  d_r, d_g, d_b;

    int total = 0;
    int bad   = 0;

    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    always #5 clk = ~clk;

    wb_tft_controller #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PCLK_DIV(2)
    ) dut (
        .clk(clk), .rst(rst),
        .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i),
        .wbs_dat_o(dat_o), .wbs_ack_o(ack), .wbs_int_o(intr),
        .red(red), .green(green), .blue(blue),
        .pclk(pclk), .disp_en(disp_en),
        .hsync(hsync), .vsync(vsync), .data_en(data_en)
    );

    wb_tft_controller dut_def (
        .clk(clk), .rst(rst),
        .wbs_we_i(1'b0), .wbs_cyc_i(d_cyc), .wbs_stb_i(d_stb),
        .wbs_adr_i(d_adr), .wbs_dat_i(32'd0),
        .wbs_dat_o(d_dat_o), .wbs_ack_o(d_ack), .wbs_int_o(d_int),
        .red(d_r), .green(d_g), .blue(d_b),
        .pclk(d_pclk), .disp_en(d_disp),
        .hsync(d_hs), .vsync(d_vs), .data_en(d_de)
    );

    task automatic wb_xfer(input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] q);
        logic got;
        got = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        q = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL wb_ack_timeout adr=%0h got=0 want=1", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'd0, q);
    endtask

    task automatic wait_de(input logic lvl);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (data_en !== lvl && n < 400);
        total++;
        if (data_en !== lvl) begin
            bad++;
            $display("FAIL wait_de got=%b want=%b", data_en, lvl);
        end
    endtask

    task automatic test_reset();
        logic [31:0] q;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({hsync, vsync, data_en, pclk, disp_en} !== 5'b11000) begin
            bad++;
            $display("FAIL rst_sync got=%b want=11000",
                     {hsync, vsync, data_en, pclk, disp_en});
        end
        total++;
        if ({red, green, blue, ack, intr, dat_o} !== 58'd0) begin
            bad++;
            $display("FAIL rst_rgb_bus got=%h want=0",
                     {red, green, blue, ack, intr, dat_o});
        end
        rst = 1'b1;
        @(negedge clk);
        rd(32'd3, q);
        total++;
        if (q !== 32'h0008_0004) begin
            bad++;
            $display("FAIL geom_small got=%h want=00080004", q);
        end
        @(posedge clk); #1;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL ack_drop got=%b want=0", ack);
        end
        @(negedge clk);
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'd3;
        @(posedge clk); #1;
        total++;
        if ({d_ack, d_dat_o} !== {1'b1, 32'h01E0_0110}) begin
            bad++;
            $display("FAIL geom_default got=%b/%h want=1/01e00110",
                     d_ack, d_dat_o);
        end
        @(posedge clk); #1;
        total++;
        if (d_ack !== 1'b0) begin
            bad++;
            $display("FAIL ack_held_stb got=%b want=0", d_ack);
        end
        d_cyc = 1'b0; d_stb = 1'b0;
    endtask

    task automatic test_fill();
        int de_n, hs_n, vs_n, rgb_bad;
        de_n = 0; hs_n = 0; vs_n = 0; rgb_bad = 0;
        wr(32'd2, 32'h00FF_8040);
        wr(32'd0, 32'h1);
        repeat (5) @(negedge clk);
        // One full frame is 12 px * 7 lines * 2 clk = 168 clk.
        for (int i = 0; i < 168; i++) begin
            @(negedge clk);
            if (data_en) de_n++;
            if (!hsync) hs_n++;
            if (!vsync) vs_n++;
            if (data_en ? ({red, green, blue} !== 24'hFF8040)
                        : ({red, green, blue} !== 24'h0))
                rgb_bad++;
        end
        total++;
        if (de_n != 64) begin
            bad++;
            $display("FAIL fill_de_clks got=%0d want=64", de_n);
        end
        total++;
        if (hs_n != 28) begin
            bad++;
            $display("FAIL fill_hsync_clks got=%0d want=28", hs_n);
        end
        total++;
        if (vs_n != 24) begin
            bad++;
            $display("FAIL fill_vsync_clks got=%0d want=24", vs_n);
        end
        total++;
        if (rgb_bad != 0) begin
            bad++;
            $display("FAIL fill_rgb bad_samples=%0d want=0", rgb_bad);
        end
        total++;
        if (disp_en !== 1'b1) begin
            bad++;
            $display("FAIL fill_disp_en got=%b want=1", disp_en);
        end
    endtask

    task automatic test_bars();
        logic [23:0] samp [16];
        wr(32'd0, 32'h5);
        wait_de(1'b0);
        wait_de(1'b1);
        samp[0] = {red, green, blue};
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            samp[i] = {red, green, blue};
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (samp[2*i] !== BARS[i]) begin
                bad++;
                $display("FAIL bar%0d got=%h want=%h", i, samp[2*i], BARS[i]);
            end
        end
    endtask

    task automatic test_frame_done();
        logic [31:0] q;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd(32'd1, q);
        total++;
        if (q !== 32'h0) begin
            bad++;
            $display("FAIL status_idle got=%h want=0", q);
        end
        wr(32'd0, 32'h3);
        repeat (120) @(negedge clk);
        total++;
        if (intr !== 1'b1) begin
            bad++;
            $display("FAIL irq_set got=%b want=1", intr);
        end
        rd(32'd1, q);
        total++;
        if (q !== 32'h3) begin
            bad++;
            $display("FAIL status_done got=%h want=3", q);
        end
        rd(32'd1, q);
        total++;
        if (q !== 32'h2) begin
            bad++;
            $display("FAIL status_clr got=%h want=2", q);
        end
        total++;
        if (intr !== 1'b0) begin
            bad++;
            $display("FAIL irq_clr got=%b want=0", intr);
        end
        rd(32'd4, q);
        total++;
        if (q !== 32'h1) begin
            bad++;
            $display("FAIL frame_count got=%h want=1", q);
        end
    endtask

    task automatic test_disable();
        wr(32'd2, 32'h0012_3456);
        wr(32'd0, 32'h1);
        wait_de(1'b0);
        wait_de(1'b1);
        wr(32'd0, 32'h0);
        @(posedge clk); #1;
        total++;
        if ({hsync, vsync, data_en, pclk, disp_en, red, green, blue}
            !== {5'b11000, 24'h0}) begin
            bad++;
            $display("FAIL dis_outputs got=%b/%h want=11000/000000",
                     {hsync, vsync, data_en, pclk, disp_en},
                     {red, green, blue});
        end
        repeat (7) @(negedge clk);
        wr(32'd0, 32'h1);
        @(posedge clk); #1;
        total++;
        if ({hsync, vsync, data_en, pclk} !== 4'b1111) begin
            bad++;
            $display("FAIL reen_first got=%b want=1111",
                     {hsync, vsync, data_en, pclk});
        end
        total++;
        if ({red, green, blue} !== 24'h123456) begin
            bad++;
            $display("FAIL reen_rgb got=%h want=123456", {red, green, blue});
        end
        @(posedge clk); #1;
        total++;
        if ({data_en, pclk} !== 2'b10) begin
            bad++;
            $display("FAIL reen_second got=%b want=10", {data_en, pclk});
        end
    endtask

    task automatic test_undecoded();
        logic [31:0] q;
        rd(32'd7, q);
        total++;
        if (q !== 32'h0) begin
            bad++;
            $display("FAIL rd_addr7 got=%h want=0", q);
        end
        @(posedge clk); #1;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL addr7_ack_drop got=%b want=0", ack);
        end
        wr(32'd6, 32'hFFFF_FFFF);
        wr(32'd3, 32'hFFFF_FFFF);
        rd(32'd0, q);
        total++;
        if (q !== 32'h1) begin
            bad++;
            $display("FAIL ctrl_kept got=%h want=1", q);
        end
        rd(32'd2, q);
        total++;
        if (q !== 32'h0012_3456) begin
            bad++;
            $display("FAIL fill_kept got=%h want=00123456", q);
        end
        rd(32'd3, q);
        total++;
        if (q !== 32'h0008_0004) begin
            bad++;
            $display("FAIL geom_kept got=%h want=00080004", q);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_bars();
        test_frame_done();
        test_disable();
        test_undecoded();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
